encoder4to2_hs: RTL and testbench
=================================

// Module: encoder4to2_hs
// PURPOSE
//  Registered 4-to-2 priority encoder, the inverse of the team's 2-to-4 decoder.
//  Captures 4 request lines into a sticky pending register and offers the 2-bit
//  code of the highest-priority pending line over a valid/ready handshake.
//  Sits between event sources and any consumer that decodes the code back to
//  one-hot (d0..d3). Bit n of req maps to code n, so code 2'b11 means d3.
// PARAMETERS
//  CODE_RST   2'b00  value of code at reset, and while idle if ZERO_IDLE=1
//  ZERO_IDLE  1      1: code forced to CODE_RST when out_valid=0; 0: code holds last value
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  asynchronous, active-high reset
//  req        in   4  request lines, sampled every clk; multi-hot allowed
//  out_ready  in   1  consumer accepts code this cycle
//  out_valid  out  1  code is valid
//  code       out  2  encoded index of granted request
//  pend       out  4  pending-request register (status)
//  merge      out  1  1-cycle pulse: an arriving req bit was already pending
// BEHAVIOUR
//  Reset (async, while rst=1): pend=0, out_valid=0, code=CODE_RST, merge=0, FSM=IDLE.
//  Handshake: fires when out_valid & out_ready. code is stable while out_valid=1 & !out_ready.
//  Pending update each edge: pend <= (pend & ~clr) | req, where clr = onehot(code) on a
//   handshake, else 0. Set wins: if req[n] rises in the cycle bit n is cleared, bit n stays 1.
//  merge <= |(req & pend & ~clr) (registered, 1 cycle).
//  FSM:
//   IDLE:  if pend!=0 -> code <= prio(pend), out_valid <= 1, go OFFER; else stay.
//   OFFER: if handshake -> out_valid <= 0, pend bit cleared, go IDLE; else hold.
//  prio() considers the registered pend only, never raw req.
//  Latency: req high in cycle N -> pend set at edge N+1 -> out_valid at edge N+2.
//  Throughput: one grant per 2 cycles minimum (IDLE bubble after each handshake).
//  A higher-priority req arriving during OFFER does not preempt; it is granted next.
//  req=0 throughout: out_valid stays 0, pend stays 0.
//  out_ready held high with no pending: no effect.
//  Reset mid-OFFER: grant dropped, pend cleared, no handshake counted.
// CONFIGURATION
//  ROUND_ROBIN_EN undefined: fixed priority, bit3 > bit2 > bit1 > bit0.
//  ROUND_ROBIN_EN defined: 2-bit pointer ptr (reset 2'd3) names the highest-priority
//   bit; the search order is ptr, ptr-1, ... (mod 4). On each handshake of code c,
//   ptr <= c-1 (mod 4), so c becomes lowest priority. All other behaviour unchanged.
// TESTING
//  T1 reset: rst=1 with req=4'hF -> out_valid=0, pend=0, code=CODE_RST; release -> out_valid at edge 2.
//  T2 single: req=4'b0100 for 1 cycle, out_ready=1 -> code=2'b10 valid 1 cycle, pend returns to 0.
//  T3 stall/multi: req=4'b1011 pulse, out_ready=0 for 5 cycles -> code=2'b11 held stable; then ready=1
//     -> grant sequence 3,1,0 (fixed), each separated by one idle cycle.
//  T4 set-wins/merge: pend[1]=1 in OFFER with code=1; req[1]=1 on the handshake cycle
//     -> pend[1] stays 1, merge=0; req[1] again while pending -> merge pulses 1.
//  T5 ROUND_ROBIN_EN: req=4'hF held, ready=1 -> codes 3,2,1,0,3 (fixed: 3,3,3...).
//  T6 reset mid-OFFER: assert rst while out_valid=1, ready=0 -> out_valid=0 immediately, pend=0.

Source files
------------

// File: rtl/encoder4to2_hs.sv
// Registered 4-to-2 priority encoder: sticky pending requests, code offered over valid/ready.
// Optional macro ROUND_ROBIN_EN selects rotating priority; default is fixed priority (bit3 highest).
module encoder4to2_hs #(
    parameter logic [1:0] CODE_RST  = 2'b00,
    parameter bit         ZERO_IDLE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [1:0] code,
    output logic [3:0] pend,
    output logic       merge
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] pend_r;
    logic [1:0] code_r;
    logic [1:0] code_nxt_s;
    logic       valid_r;
    logic       valid_nxt_s;
    logic       merge_r;
    logic       hs_s;
    logic [3:0] clr_s;
    logic [1:0] top_s;

    function automatic logic [3:0] onehot_f(input logic [1:0] c);
        onehot_f = 4'b0001 << c;
    endfunction

    // Searches top, top-1, ... (mod 4); walking the offsets downward lets the closest hit win.
    function automatic logic [1:0] prio_f(input logic [3:0] p, input logic [1:0] top);
        logic [1:0] idx;
        prio_f = top;
        for (int i = 3; i >= 0; i--) begin
            idx    = top - 2'(i);
            prio_f = p[idx] ? idx : prio_f;
        end
    endfunction

    assign hs_s  = valid_r & out_ready;
    assign clr_s = hs_s ? onehot_f(code_r) : 4'b0000;

`ifdef ROUND_ROBIN_EN
    logic [1:0] ptr_r;

    // Rotating pointer: the code just granted becomes the lowest priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= 2'd3;
        end else if (hs_s) begin
            ptr_r <= code_r - 2'd1;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign top_s = ptr_r;
`else
    assign top_s = 2'd3;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (pend_r != 4'b0000) begin
                    state_nxt_s = OFFER;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            OFFER: begin
                if (hs_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = OFFER;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of the registered outputs; priority looks only at the registered pend.
    always_comb begin
        valid_nxt_s = valid_r;
        code_nxt_s  = code_r;
        case (state_r)
            IDLE: begin
                if (pend_r != 4'b0000) begin
                    valid_nxt_s = 1'b1;
                    code_nxt_s  = prio_f(pend_r, top_s);
                end else begin
                    valid_nxt_s = 1'b0;
                    code_nxt_s  = ZERO_IDLE ? CODE_RST : code_r;
                end
            end
            OFFER: begin
                if (hs_s) begin
                    valid_nxt_s = 1'b0;
                    code_nxt_s  = ZERO_IDLE ? CODE_RST : code_r;
                end else begin
                    valid_nxt_s = 1'b1;
                    code_nxt_s  = code_r;
                end
            end
            default: begin
                valid_nxt_s = 1'b0;
                code_nxt_s  = CODE_RST;
            end
        endcase
    end

    // Output and pending registers; a request arriving on the clear cycle keeps its bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r  <= 4'b0000;
            code_r  <= CODE_RST;
            valid_r <= 1'b0;
            merge_r <= 1'b0;
        end else begin
            pend_r  <= (pend_r & ~clr_s) | req;
            code_r  <= code_nxt_s;
            valid_r <= valid_nxt_s;
            merge_r <= |(req & pend_r & ~clr_s);
        end
    end

    assign out_valid = valid_r;
    assign code      = code_r;
    assign pend      = pend_r;
    assign merge     = merge_r;

endmodule

// File: tb/tb_encoder4to2_hs.sv
// Scoreboard bench for encoder4to2_hs: a set-based reference model predicts grants and status,
// a negedge monitor compares them. Honours ROUND_ROBIN_EN when defined for both files.
module tb_encoder4to2_hs;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       out_ready;
    logic       out_valid;
    logic [1:0] code;
    logic [3:0] pend;
    logic       merge;

    encoder4to2_hs dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .code     (code),
        .pend     (pend),
        .merge    (merge)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       v;
        logic [1:0] c;
        logic [3:0] p;
        logic       m;
    } obs_t;

    obs_t exp_obs_q[$];
    int   exp_code_q[$];
    int   seen_q[$];
    int   want_q[$];

    // Reference model: a set of pending request numbers, an "offering" flag and the offered number.
    bit m_pend[4];
    bit m_offer;
    int m_code;
    int m_ptr;
    bit m_merge;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 4; n++) m_pend[n] = 1'b0;
        m_offer = 1'b0;
        m_code  = 0;
        m_ptr   = 3;
        m_merge = 1'b0;
    endtask

    function automatic int pick_model();
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_ptr - k + 4) % 4;
            if (m_pend[idx]) return idx;
        end
        return 0;
    endfunction

    // Drive one cycle of stimulus, record what the DUT must show this cycle, advance the model.
    task automatic step(input logic [3:0] r, input logic rdy);
        obs_t o;
        bit   hs;
        bit   anyp;
        bit   clr;
        bit   nm;
        int   cand;
        int   gc;
        req       = r;
        out_ready = rdy;
        o.v = m_offer;
        o.c = m_offer ? 2'(m_code) : 2'b00;
        for (int n = 0; n < 4; n++) o.p[n] = m_pend[n];
        o.m = m_merge;
        exp_obs_q.push_back(o);
        hs = m_offer && rdy;
        if (hs) exp_code_q.push_back(m_code);
        anyp = 1'b0;
        for (int n = 0; n < 4; n++) if (m_pend[n]) anyp = 1'b1;
        cand = pick_model();
        gc   = m_code;
        nm   = 1'b0;
        for (int n = 0; n < 4; n++) begin
            clr = hs && (n == gc);
            if (r[n] && m_pend[n] && !clr) nm = 1'b1;
            m_pend[n] = (m_pend[n] && !clr) || r[n];
        end
        m_merge = nm;
        if (!m_offer) begin
            if (anyp) begin
                m_offer = 1'b1;
                m_code  = cand;
            end
        end else if (hs) begin
            m_offer = 1'b0;
`ifdef ROUND_ROBIN_EN
            m_ptr = (gc + 3) % 4;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset away from the clock edge and verify it takes effect without a clock.
    task automatic do_reset();
        rst       = 1'b1;
        req       = 4'hF;
        out_ready = 1'b0;
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_pend", int'(pend), 0);
        check("rst_code", int'(code), 0);
        check("rst_merge", int'(merge), 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_valid", int'(out_valid), 0);
        check("rst_hold_pend", int'(pend), 0);
        rst = 1'b0;
        model_reset();
        seen_q.delete();
    endtask

    task automatic check_seq(input string name);
        check({name, "_count"}, seen_q.size(), want_q.size());
        for (int i = 0; i < want_q.size(); i++)
            check(name, (i < seen_q.size()) ? seen_q[i] : -1, want_q[i]);
    endtask

    // Monitor: compares handshakes against the grant queue and per-cycle status against the model.
    always @(negedge clk) begin
        obs_t o;
        if (!rst && out_valid && out_ready) begin
            seen_q.push_back(int'(code));
            if (exp_code_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL grant: got code %0d expected no handshake at %0t", code, $time);
            end else begin
                check("grant_code", int'(code), exp_code_q.pop_front());
            end
        end
        if (exp_obs_q.size() != 0) begin
            o = exp_obs_q.pop_front();
            check("out_valid", int'(out_valid), int'(o.v));
            check("code", int'(code), int'(o.c));
            check("pend", int'(pend), int'(o.p));
            check("merge", int'(merge), int'(o.m));
        end
    end

    initial begin
        rst       = 1'b0;
        req       = 4'h0;
        out_ready = 1'b0;
        model_reset();
        #2;

        // T1: reset with all requests high, then out_valid two edges after release.
        do_reset();
        step(4'hF, 1'b0);
        check("t1_edge1_valid", int'(out_valid), 0);
        step(4'hF, 1'b0);
        check("t1_edge2_valid", int'(out_valid), 1);
        check("t1_edge2_code", int'(code), 3);

        // T6: reset while offering and stalled.
        step(4'h0, 1'b0);
        check("t6_pre_valid", int'(out_valid), 1);
        do_reset();

        // T2: single request, consumer always ready.
        req = 4'h0;
        step(4'b0100, 1'b1);
        repeat (3) step(4'h0, 1'b1);
        want_q.delete();
        want_q.push_back(2);
        check_seq("t2_seq");
        check("t2_pend_empty", int'(pend), 0);

        // T3: multi-hot pulse, stall five cycles, then drain.
        seen_q.delete();
        step(4'b1011, 1'b0);
        repeat (5) step(4'h0, 1'b0);
        check("t3_stall_code", int'(code), 3);
        repeat (8) step(4'h0, 1'b1);
        want_q.delete();
        want_q.push_back(3);
        want_q.push_back(1);
        want_q.push_back(0);
        check_seq("t3_seq");

        // T4: request on the clearing cycle keeps the bit; repeated request while pending merges.
        step(4'b0010, 1'b0);
        step(4'h0, 1'b0);
        check("t4_offer_code", int'(code), 1);
        step(4'b0010, 1'b1);
        check("t4_setwins_pend1", int'(pend[1]), 1);
        check("t4_no_merge", int'(merge), 0);
        step(4'b0010, 1'b0);
        check("t4_merge_pulse", int'(merge), 1);
        repeat (4) step(4'h0, 1'b1);

        // T5: all requests held, always ready.
        do_reset();
        repeat (12) step(4'hF, 1'b1);
        want_q.delete();
`ifdef ROUND_ROBIN_EN
        want_q.push_back(3);
        want_q.push_back(2);
        want_q.push_back(1);
        want_q.push_back(0);
        want_q.push_back(3);
`else
        repeat (5) want_q.push_back(3);
`endif
        check_seq("t5_seq");
        repeat (4) step(4'h0, 1'b1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic [3:0] r;
            logic       rdy;
            if ($urandom_range(0, 149) == 0) do_reset();
            r   = 4'($urandom) & 4'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            step(r, rdy);
        end
        repeat (10) step(4'h0, 1'b1);

        check("grant_queue_drained", exp_code_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
